// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, entry width and pointer sizing for the packet controller
package uart_pkg;
    typedef enum logic [1:0] {PKT_IDLE, PKT_RECV, PKT_DROP} pkt_state_e;
    localparam int ENTRY_W = 9;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/uart_rx_pkt_ctrl_if.sv
// uart_rx_pkt_ctrl_if: receiver-side strobes and downstream byte stream of the packet controller
interface uart_rx_pkt_ctrl_if #(parameter int LEN_W = 4);
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic             rx_eop;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             out_ready;
    logic             pkt_done;
    logic [LEN_W-1:0] pkt_len;
    logic             overflow;
    logic             clr_err;
    modport master(
        output rx_ready, rx_data, rx_eop, out_ready, clr_err,
        input  out_valid, out_data, out_last, pkt_done, pkt_len, overflow
    );
    modport slave(
        input  rx_ready, rx_data, rx_eop, out_ready, clr_err,
        output out_valid, out_data, out_last, pkt_done, pkt_len, overflow
    );
endinterface

// File: rtl/uart_pkt_ram.sv
// uart_pkt_ram: DEPTH x {last, byte} storage, sync write, sync last-bit set, async read
module uart_pkt_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               lwe,
    input  logic [AW-1:0]      laddr,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (lwe) mem_q[laddr][ENTRY_W-1] <= 1'b1;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: assembles UART bytes into packets, releases only whole ones; UART_RX_PKT_STATS_EN adds pkt/drop counters
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 15
) (
    input logic                clk,
    input logic                rst_n,
    uart_rx_pkt_ctrl_if.slave  bus
`ifdef UART_RX_PKT_STATS_EN
    ,
    output logic [15:0]        pkt_cnt,
    output logic [15:0]        drop_cnt
`endif
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    pkt_state_e state_q, state_d;
    logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, wr_inc;
    logic [LW-1:0] len_q, len_d, pkt_len_q, pkt_len_d, len_inc;
    logic done_q, done_d, ovf_q, ovf_d;
    logic full, valid, pop, we, lwe, drop;
    logic [ENTRY_W-1:0] rdata;

    // Full is judged against the pre-pop read pointer
    assign full    = (wr_q - rd_q) == DEPTH_P;
    assign valid   = rd_q != cm_q;
    assign pop     = valid & bus.out_ready;
    assign wr_inc  = wr_q + PW'(1);
    assign len_inc = len_q + LW'(1);

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        cm_d      = cm_q;
        len_d     = len_q;
        pkt_len_d = pkt_len_q;
        done_d    = 1'b0;
        we        = 1'b0;
        lwe       = 1'b0;
        drop      = 1'b0;
        rd_d      = rd_q + PW'(pop);
        case (state_q)
            PKT_IDLE: if (bus.rx_ready) begin
                if (full) begin
                    drop    = 1'b1;
                    state_d = bus.rx_eop ? PKT_IDLE : PKT_DROP;
                end else begin
                    we      = 1'b1;
                    wr_d    = wr_inc;
                    len_d   = LW'(1);
                    state_d = PKT_RECV;
                    if (bus.rx_eop) begin
                        cm_d      = wr_inc;
                        pkt_len_d = LW'(1);
                        done_d    = 1'b1;
                        state_d   = PKT_IDLE;
                    end
                end
            end
            PKT_RECV: if (bus.rx_ready) begin
                if (full || len_q == LW'(MAX_LEN)) begin
                    drop    = 1'b1;
                    wr_d    = cm_q;
                    state_d = bus.rx_eop ? PKT_IDLE : PKT_DROP;
                end else begin
                    we    = 1'b1;
                    wr_d  = wr_inc;
                    len_d = len_inc;
                    if (bus.rx_eop) begin
                        cm_d      = wr_inc;
                        pkt_len_d = len_inc;
                        done_d    = 1'b1;
                        state_d   = PKT_IDLE;
                    end
                end
            end else if (bus.rx_eop) begin
                lwe       = 1'b1;
                cm_d      = wr_q;
                pkt_len_d = len_q;
                done_d    = 1'b1;
                state_d   = PKT_IDLE;
            end
            PKT_DROP: state_d = bus.rx_eop ? PKT_IDLE : PKT_DROP;
            default:  state_d = PKT_IDLE;
        endcase
        ovf_d = drop | (ovf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PKT_IDLE;
            wr_q      <= '0;
            cm_q      <= '0;
            rd_q      <= '0;
            len_q     <= '0;
            pkt_len_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            cm_q      <= cm_d;
            rd_q      <= rd_d;
            len_q     <= len_d;
            pkt_len_q <= pkt_len_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    // The last bit rides along with the byte when rx_eop coincides with rx_ready
    uart_pkt_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_q[AW-1:0]),
        .wdata ({bus.rx_eop, bus.rx_data}),
        .lwe   (lwe),
        .laddr (AW'(wr_q - PW'(1))),
        .raddr (rd_q[AW-1:0]),
        .rdata (rdata)
    );

    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? rdata[7:0] : 8'h00;
    assign bus.out_last  = valid & rdata[ENTRY_W-1];
    assign bus.pkt_done  = done_q;
    assign bus.pkt_len   = pkt_len_q;
    assign bus.overflow  = ovf_q;

`ifdef UART_RX_PKT_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = bus.clr_err ? 16'h0 : pkt_cnt_q + 16'(done_q && pkt_cnt_q != 16'hFFFF);
        drop_cnt_d = bus.clr_err ? 16'h0 :
                     drop_cnt_q + 16'(drop && state_d == PKT_DROP && drop_cnt_q != 16'hFFFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb_uart_rx_pkt_ctrl: randomized packet traffic checked against a packet-level queue model
module tb_uart_rx_pkt_ctrl;
    localparam int DEPTH   = 16;
    localparam int MAX_LEN = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int passed = 0;
    byte unsigned pkt[$];
    byte unsigned q_data[$];
    bit q_last[$];
    int exp_len = 0;
    bit exp_ovf = 1'b0;

    uart_rx_pkt_ctrl_if #(.LEN_W(4)) bus();

`ifdef UART_RX_PKT_STATS_EN
    logic [15:0] pkt_cnt, drop_cnt;
`endif

    uart_rx_pkt_ctrl #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef UART_RX_PKT_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // mode 0: separate rx_eop, 1: rx_eop with last byte, 2: no rx_eop
    task automatic send(input int mode);
        int pend = 0;
        bit dropping = 1'b0;
        bit committed;
        for (int i = 0; i < pkt.size(); i++) begin
            bus.rx_ready = 1'b1;
            bus.rx_data  = pkt[i];
            bus.rx_eop   = (mode == 1) && (i == pkt.size() - 1);
            if (!dropping) begin
                if (q_data.size() + pend == DEPTH || pend == MAX_LEN) begin
                    dropping = 1'b1;
                    exp_ovf  = 1'b1;
                end else pend++;
            end
            @(negedge clk);
            bus.rx_ready = 1'b0;
            bus.rx_eop   = 1'b0;
            if (!(mode == 1 && i == pkt.size() - 1)) repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        if (mode == 2) return;
        if (mode == 0) begin
            bus.rx_eop = 1'b1;
            @(negedge clk);
            bus.rx_eop = 1'b0;
        end
        committed = !dropping && pend > 0;
        if (committed) begin
            for (int i = 0; i < pend; i++) begin
                q_data.push_back(pkt[i]);
                q_last.push_back(i == pend - 1);
            end
            exp_len = pend;
        end
        total++;
        if (bus.pkt_done !== committed) $display("FAIL pkt_done: got %b want %b", bus.pkt_done, committed);
        else passed++;
        total++;
        if (bus.pkt_len !== 4'(exp_len)) $display("FAIL pkt_len: got %0d want %0d", bus.pkt_len, exp_len);
        else passed++;
        total++;
        if (bus.overflow !== exp_ovf) $display("FAIL overflow: got %b want %b", bus.overflow, exp_ovf);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.pkt_done !== 1'b0) $display("FAIL pkt_done_pulse: got %b want 0", bus.pkt_done);
        else passed++;
    endtask

    task automatic drain(input int pct);
        int budget = 0;
        while (q_data.size() > 0 && budget < 2000) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== q_data[0] || bus.out_last !== q_last[0])
                $display("FAIL stream: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         bus.out_valid, bus.out_data, bus.out_last, q_data[0], q_last[0]);
            else passed++;
            if ($urandom_range(0, 99) < pct) begin
                bus.out_ready = 1'b1;
                void'(q_data.pop_front());
                void'(q_last.pop_front());
            end else bus.out_ready = 1'b0;
            @(negedge clk);
            budget++;
        end
        bus.out_ready = 1'b0;
        total++;
        if (q_data.size() != 0 || bus.out_valid !== 1'b0)
            $display("FAIL drain_end: got v=%b left=%0d want v=0 left=0", bus.out_valid, q_data.size());
        else passed++;
    endtask

    task automatic clear_err();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        exp_ovf = 1'b0;
        total++;
        if (bus.overflow !== 1'b0) $display("FAIL clr_err: got %b want 0", bus.overflow);
        else passed++;
    endtask

    task automatic fill_rand(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
        else passed++;
        total++;
        if (bus.out_data !== 8'h00) $display("FAIL rst_out_data: got %h want 00", bus.out_data);
        else passed++;
        total++;
        if (bus.out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", bus.out_last);
        else passed++;
        total++;
        if (bus.pkt_done !== 1'b0) $display("FAIL rst_pkt_done: got %b want 0", bus.pkt_done);
        else passed++;
        total++;
        if (bus.pkt_len !== 4'd0) $display("FAIL rst_pkt_len: got %0d want 0", bus.pkt_len);
        else passed++;
        total++;
        if (bus.overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", bus.overflow);
        else passed++;
        q_data.delete();
        q_last.delete();
        exp_len = 0;
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        pkt.delete();
        pkt.push_back(8'h41);
        pkt.push_back(8'h42);
        pkt.push_back(8'h43);
        send(0);
        drain(100);
    endtask

    task automatic test_back_to_back_wrap();
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 3; p++) begin
                fill_rand(5);
                send($urandom_range(0, 1));
            end
            drain(70);
        end
    endtask

    task automatic test_overflow();
        fill_rand(12);
        send(0);
        fill_rand(6);
        send(0);
        fill_rand(2);
        send(0);
        drain(80);
        clear_err();
    endtask

    task automatic test_oversize();
        fill_rand(16);
        send(0);
        drain(100);
        clear_err();
    endtask

    task automatic test_corner();
        pkt.delete();
        send(0);
        pkt.push_back(8'h7E);
        send(1);
        drain(100);
    endtask

    task automatic test_reset_mid();
        fill_rand(4);
        send(0);
        fill_rand(3);
        send(2);
        test_reset();
        fill_rand(2);
        send(0);
        drain(100);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            fill_rand($urandom_range(0, 17));
            send(pkt.size() > 0 ? int'($urandom_range(0, 1)) : 0);
            if ($urandom_range(0, 2) == 0) drain(60);
            if ($urandom_range(0, 4) == 0) clear_err();
        end
        drain(50);
    endtask

    initial begin
        bus.rx_ready  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_eop    = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_err   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back_wrap();
        test_overflow();
        test_oversize();
        test_corner();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
